// File: rtl/register_bank_param_if.sv
// Bus bundle for register_bank_param: one write port, two read ports, status.
// The master drives requests; the slave (the bank) returns read data and status.
interface register_bank_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              WR;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] data_in;
    logic              RD_A;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] Data_out_a;
    logic              valid_a;
    logic              RD_B;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] Data_out_b;
    logic              valid_b;
    logic              busy;
    logic              err;

    modport master (
        output clr, WR, wr_addr, data_in, RD_A, rd_addr_a, RD_B, rd_addr_b,
        input  Data_out_a, valid_a, Data_out_b, valid_b, busy, err
    );

    modport slave (
        input  clr, WR, wr_addr, data_in, RD_A, rd_addr_a, RD_B, rd_addr_b,
        output Data_out_a, valid_a, Data_out_b, valid_b, busy, err
    );
endinterface

// File: rtl/register_bank_param.sv
// Parametrised register bank with one write port, two registered read ports
// and a self-clearing sweep that writes RESET_VAL to every entry.
module register_bank_param #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    register_bank_param_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              err_reg;
    logic              idle;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_in_range;
    logic              reject;
    logic [1:0]        rd_oor;

    // Storage carries no reset so it can map onto distributed RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];

    assign idle        = (state_reg == IDLE);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign rd_en[0]    = bus.RD_A;
    assign rd_en[1]    = bus.RD_B;
    assign rd_addr[0]  = bus.rd_addr_a;
    assign rd_addr[1]  = bus.rd_addr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // The sweep and the user write share the single RAM write port.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.data_in;
        case (state_reg)
            IDLE: begin
                mem_we = bus.WR && wr_in_range;
                if (bus.clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = RESET_VAL;
                ptr_next  = ptr_reg + 1'b1;
                if (ptr_reg == LAST_PTR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              in_range;
            logic              wr_hit;
            logic [DATA_W-1:0] dout_reg;
            logic              valid_reg;

            assign in_range   = ({1'b0, rd_addr[gi]} < DEPTH_W);
            assign wr_hit     = bus.WR && (bus.wr_addr == rd_addr[gi]);
            assign rd_oor[gi] = rd_en[gi] && !in_range;

            // Write-first: a same-address write in this cycle bypasses the RAM.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= idle && rd_en[gi];
                    if (idle && rd_en[gi]) begin
                        if (!in_range) begin
                            dout_reg <= '0;
                        end else if (wr_hit) begin
                            dout_reg <= bus.data_in;
                        end else begin
                            dout_reg <= mem[rd_addr[gi]];
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        reject = 1'b0;
        if (idle) begin
            reject = (bus.WR && !wr_in_range) || (|rd_oor);
        end else begin
            reject = bus.WR || bus.RD_A || bus.RD_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= reject;
        end
    end

    assign bus.Data_out_a = g_rd[0].dout_reg;
    assign bus.valid_a    = g_rd[0].valid_reg;
    assign bus.Data_out_b = g_rd[1].dout_reg;
    assign bus.valid_b    = g_rd[1].valid_reg;
    assign bus.busy       = !idle;
    assign bus.err        = err_reg;
endmodule
